// File: rtl/mem_pkg.sv
// Shared definitions for the ping-pong input memory: bank states and default sizes.
package mem_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 15;

  // Lifecycle of one bank: filled by the writer, handed over, streamed out, released.
  typedef enum logic [1:0] {
    BankEmpty   = 2'd0,
    BankFull    = 2'd1,
    BankReading = 2'd2
  } bank_st_e;

endpackage

// File: rtl/mem_bank.sv
// One 1R1W synchronous memory bank with a registered read port (1-cycle latency).
module mem_bank #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 15
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Array write and registered read; rd_data holds when no read is issued.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/mem_in_pingpong.sv
// Two-bank ping-pong input buffer: the writer fills one bank while the reader
// streams the other; banks are handed over with wr_done and released on the last read.
module mem_in_pingpong
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_done,
  output logic              wr_ready,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W:0]   rd_len,
  input  logic              rd_hold,
  output logic              rd_avail,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_done,
  output logic [1:0]        err
);

  localparam logic [ADDR_W:0] CntOne  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] CntFull = {1'b1, {ADDR_W{1'b0}}};

  bank_st_e          bank_q [2];
  bank_st_e          bank_d [2];
  logic              wp_q, wp_d;
  logic              rp_q, rp_d;
  logic              active_q, active_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [1:0]        err_q, err_d;
  logic              rd_valid_q, rd_done_q, rd_bank_q;
  logic              issue, last_issue;
  logic [DATA_W-1:0] bank_rd_data [2];

  assign wr_ready   = (bank_q[wp_q] == BankEmpty);
  assign rd_avail   = (bank_q[rp_q] == BankFull);
  assign issue      = active_q & ~rd_hold;
  assign last_issue = issue && (cnt_q == CntOne);

  // Bank handover, stream control and sticky error flags.
  always_comb begin
    bank_d   = bank_q;
    wp_d     = wp_q;
    rp_d     = rp_q;
    active_d = active_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;

    if (wr_en && !wr_ready) begin
      err_d[0] = 1'b1;
    end
    // A same-cycle wr_en lands in the array before the bank is marked FULL.
    if (wr_done) begin
      if (wr_ready) begin
        bank_d[wp_q] = BankFull;
        wp_d         = ~wp_q;
      end else begin
        err_d[0] = 1'b1;
      end
    end

    if (rd_start) begin
      if (rd_avail && !active_q) begin
        bank_d[rp_q] = BankReading;
        addr_d       = rd_base;
        cnt_d        = (rd_len == '0) ? CntFull : rd_len;
        active_d     = 1'b1;
      end else begin
        err_d[1] = 1'b1;
      end
    end

    // rd_start is only accepted while idle, so it never coincides with an issue.
    if (issue) begin
      addr_d = addr_q + 1'b1;
      cnt_d  = cnt_q - CntOne;
      if (last_issue) begin
        active_d     = 1'b0;
        bank_d[rp_q] = BankEmpty;
        rp_d         = ~rp_q;
      end
    end
  end

  // State and output registers; memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q[0]  <= BankEmpty;
      bank_q[1]  <= BankEmpty;
      wp_q       <= 1'b0;
      rp_q       <= 1'b0;
      active_q   <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      err_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_done_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
    end else begin
      bank_q     <= bank_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      active_q   <= active_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rd_valid_q <= issue;
      rd_done_q  <= last_issue;
      if (issue) begin
        rd_bank_q <= rp_q;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    mem_bank #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk     (clk),
      .wr_en   (wr_en && wr_ready && (wp_q == 1'(b))),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (issue && (rp_q == 1'(b))),
      .rd_addr (addr_q),
      .rd_data (bank_rd_data[b])
    );
  end

  assign rd_valid = rd_valid_q;
  assign rd_done  = rd_done_q;
  assign rd_data  = bank_rd_data[rd_bank_q];
  assign err      = err_q;

endmodule

// File: tb/tb_mem_in_pingpong.sv
// Scoreboard bench for mem_in_pingpong: expected words are queued when a stream
// is started and popped as rd_valid beats arrive.
module tb_mem_in_pingpong;

  localparam int DW = 8;
  localparam int AW = 15;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          reset, wr_en, wr_done, rd_start, rd_hold;
  logic [AW-1:0] wr_addr, rd_base;
  logic [DW-1:0] wr_data;
  logic [AW:0]   rd_len;
  logic          wr_ready, rd_avail, rd_valid, rd_done;
  logic [DW-1:0] rd_data;
  logic [1:0]    err;

  mem_in_pingpong dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_done  (wr_done),
    .wr_ready (wr_ready),
    .rd_start (rd_start),
    .rd_base  (rd_base),
    .rd_len   (rd_len),
    .rd_hold  (rd_hold),
    .rd_avail (rd_avail),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_done  (rd_done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int beats, dones, first_cyc, last_cyc, start_cyc;
  logic [8:0] sb [$];
  logic wr_low;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: compare each beat against the scoreboard head.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!reset) begin
      if (rd_done && !rd_valid) check_eq("done_without_valid", 1, 0);
      if (rd_valid) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_beat", 1, 0);
        end else begin
          e = sb.pop_front();
          check_eq("rd_data", 32'(rd_data), 32'(e[7:0]));
          check_eq("rd_done", 32'(rd_done), 32'(e[8]));
        end
        if (beats == 0) first_cyc = cyc;
        last_cyc = cyc;
        beats++;
        if (rd_done) dones++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = DW'(d);
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic close_bank();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
  endtask

  task automatic start_rd(input int base, input int len);
    beats    = 0;
    dones    = 0;
    rd_start = 1'b1;
    rd_base  = AW'(base);
    rd_len   = (AW + 1)'(len);
    tick();
    start_cyc = cyc;
    rd_start  = 1'b0;
  endtask

  task automatic push(input int d, input bit last);
    sb.push_back({last, DW'(d)});
  endtask

  // Wait for the queue to empty, then check beat count, latency and idle gaps.
  task automatic drain(input string tag, input int n, input int gap);
    int i;
    wr_low = 1'b0;
    for (i = 0; i < 400 && sb.size() != 0; i++) begin
      tick();
      if (!wr_ready) wr_low = 1'b1;
    end
    check_eq({tag, "_drain"}, sb.size(), 0);
    repeat (2) tick();
    check_eq({tag, "_beats"}, beats, n);
    check_eq({tag, "_dones"}, dones, 1);
    check_eq({tag, "_latency"}, first_cyc - start_cyc, 1);
    check_eq({tag, "_gap"}, last_cyc - first_cyc + 1 - beats, gap);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; wr_en = 0; wr_done = 0; rd_start = 0; rd_hold = 0;
    wr_addr = '0; wr_data = '0; rd_base = '0; rd_len = '0;
    beats = 0; dones = 0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_eq("rst_wr_ready", wr_ready, 1);
    check_eq("rst_rd_avail", rd_avail, 0);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_err", err, 0);

    // Basic fill then stream of bank0.
    for (int i = 0; i < 16; i++) wr_word(i, i % 256);
    close_bank();
    check_eq("t1_wr_ready", wr_ready, 1);
    check_eq("t1_rd_avail", rd_avail, 1);
    for (int i = 0; i < 16; i++) push(i, i == 15);
    start_rd(0, 16);
    drain("t1", 16, 0);
    check_eq("t1_wr_ready_throughout", wr_low, 0);
    check_eq("t1_rd_avail_after", rd_avail, 0);

    // Stream one bank while filling the other with 0xA5.
    for (int i = 0; i < 16; i++) wr_word(i, 3 * i + 7);
    close_bank();
    for (int i = 0; i < 16; i++) push(3 * i + 7, i == 15);
    fork
      start_rd(0, 16);
      begin
        for (int i = 0; i < 16; i++) wr_word(i, 8'hA5);
        close_bank();
      end
    join
    drain("t2a", 16, 0);
    check_eq("t2_rd_avail", rd_avail, 1);
    for (int i = 0; i < 16; i++) push(8'hA5, i == 15);
    start_rd(0, 16);
    drain("t2b", 16, 0);

    // Both banks full: extra write is rejected and data is untouched.
    for (int i = 0; i < 4; i++) wr_word(i, 8'h30 + i);
    close_bank();
    for (int i = 0; i < 4; i++) wr_word(i, 8'h60 + i);
    close_bank();
    check_eq("t3_err_before", err, 0);
    check_eq("t3_wr_ready", wr_ready, 0);
    wr_word(0, 8'hFF);
    check_eq("t3_err0", err, 2'b01);
    for (int i = 0; i < 4; i++) push(8'h30 + i, i == 3);
    start_rd(0, 4);
    drain("t3a", 4, 0);
    for (int i = 0; i < 4; i++) push(8'h60 + i, i == 3);
    start_rd(0, 4);
    drain("t3b", 4, 0);

    // Address wrap at the end of the bank.
    wr_word(N - 2, 8'h11);
    wr_word(N - 1, 8'h22);
    wr_word(0, 8'h33);
    wr_word(1, 8'h44);
    close_bank();
    push(8'h11, 0); push(8'h22, 0); push(8'h33, 0); push(8'h44, 1);
    start_rd(N - 2, 4);
    drain("t4", 4, 0);

    // Three-cycle hold mid-stream.
    for (int i = 0; i < 16; i++) wr_word(i, i ^ 8'h5A);
    close_bank();
    for (int i = 0; i < 16; i++) push(i ^ 8'h5A, i == 15);
    start_rd(0, 16);
    repeat (4) tick();
    rd_hold = 1'b1;
    repeat (3) tick();
    rd_hold = 1'b0;
    drain("t5", 16, 3);

    // Reset mid-stream, then a start with both banks empty.
    for (int i = 0; i < 16; i++) wr_word(i, 8'hC0 + i);
    close_bank();
    for (int i = 0; i < 16; i++) push(8'hC0 + i, i == 15);
    start_rd(0, 16);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    beats = 0;
    repeat (20) tick();
    check_eq("t6_no_valid_after_reset", beats, 0);
    check_eq("t6_err_cleared", err, 0);
    check_eq("t6_rd_avail", rd_avail, 0);
    start_rd(0, 16);
    repeat (10) tick();
    check_eq("t6_no_valid_empty_start", beats, 0);
    check_eq("t6_err1", err, 2'b10);
    check_eq("t6_wr_ready", wr_ready, 1);

    // Contents survive reset: re-close bank0 untouched and read it back.
    close_bank();
    check_eq("t6_rd_avail_reclose", rd_avail, 1);
    for (int i = 0; i < 4; i++) push(i ^ 8'h5A, i == 3);
    start_rd(0, 4);
    drain("t6", 4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
